// File: rtl/idle_detect_lanes.sv
// Per-lane COM-lock / IDL detector: each lane locks after LOCK_COUNT COM symbols,
// flags IDL while locked, and drops lock after UNLOCK_COUNT consecutive bad symbols.
module idle_detect_lanes #(
   parameter int               LANES        = 4,
   parameter int               SYM_W        = 8,
   parameter logic [SYM_W-1:0] COM_SYM      = 8'hBC,
   parameter logic [SYM_W-1:0] IDL_SYM      = 8'h7C,
   parameter int               LOCK_COUNT   = 4,
   parameter int               UNLOCK_COUNT = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [LANES*SYM_W-1:0] sym_in,
   input  logic [LANES-1:0]       sym_valid,
   output logic [LANES-1:0]       idle_out,
   output logic [LANES-1:0]       lane_locked,
   output logic                   all_lanes_idle
);

   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } lane_state_e;

   lane_state_e       state_q   [LANES];
   lane_state_e       state_d   [LANES];
   logic [CW-1:0]     com_cnt_q [LANES];
   logic [CW-1:0]     com_cnt_d [LANES];
   logic [BW-1:0]     bad_cnt_q [LANES];
   logic [BW-1:0]     bad_cnt_d [LANES];
   logic [LANES-1:0]  idle_q;
   logic [LANES-1:0]  idle_d;
   logic              all_idle_q;
   logic              all_idle_d;

   // Next-state for every lane; clear wins over sym_valid, invalid cycles hold state.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         state_d[i]   = state_q[i];
         com_cnt_d[i] = com_cnt_q[i];
         bad_cnt_d[i] = bad_cnt_q[i];
         idle_d[i]    = 1'b0;
         if (clear) begin
            state_d[i]   = ST_SEARCH;
            com_cnt_d[i] = {CW{1'b0}};
            bad_cnt_d[i] = {BW{1'b0}};
         end else if (sym_valid[i]) begin
            case (state_q[i])
               ST_SEARCH: begin
                  if (sym_in[i*SYM_W +: SYM_W] == COM_SYM) begin
                     if (com_cnt_q[i] != CW'(LOCK_COUNT)) begin
                        com_cnt_d[i] = com_cnt_q[i] + CW'(1);
                     end else begin
                        com_cnt_d[i] = com_cnt_q[i];
                     end
                     if (com_cnt_q[i] == CW'(LOCK_COUNT - 1)) begin
                        state_d[i] = ST_LOCKED;
                     end else begin
                        state_d[i] = ST_SEARCH;
                     end
                  end else begin
                     com_cnt_d[i] = com_cnt_q[i];
                  end
               end
               ST_LOCKED: begin
                  if (sym_in[i*SYM_W +: SYM_W] == IDL_SYM) begin
                     idle_d[i]    = 1'b1;
                     bad_cnt_d[i] = {BW{1'b0}};
                  end else if (sym_in[i*SYM_W +: SYM_W] == COM_SYM) begin
                     bad_cnt_d[i] = {BW{1'b0}};
                  end else if (bad_cnt_q[i] == BW'(UNLOCK_COUNT - 1)) begin
                     // Run of bad symbols complete: lane must reacquire from scratch.
                     state_d[i]   = ST_SEARCH;
                     com_cnt_d[i] = {CW{1'b0}};
                     bad_cnt_d[i] = {BW{1'b0}};
                  end else if (bad_cnt_q[i] != BW'(UNLOCK_COUNT)) begin
                     bad_cnt_d[i] = bad_cnt_q[i] + BW'(1);
                  end else begin
                     bad_cnt_d[i] = bad_cnt_q[i];
                  end
               end
               default: begin
                  state_d[i]   = ST_SEARCH;
                  com_cnt_d[i] = {CW{1'b0}};
                  bad_cnt_d[i] = {BW{1'b0}};
               end
            endcase
         end else begin
            state_d[i] = state_q[i];
         end
      end
      all_idle_d = &idle_d;
   end

   // Lane state, counters and registered idle flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i]   <= ST_SEARCH;
            com_cnt_q[i] <= {CW{1'b0}};
            bad_cnt_q[i] <= {BW{1'b0}};
         end
         idle_q     <= {LANES{1'b0}};
         all_idle_q <= 1'b0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i]   <= state_d[i];
            com_cnt_q[i] <= com_cnt_d[i];
            bad_cnt_q[i] <= bad_cnt_d[i];
         end
         idle_q     <= idle_d;
         all_idle_q <= all_idle_d;
      end
   end

   // Lock flag is a direct decode of the registered lane state.
   always_comb begin
      lane_locked = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         lane_locked[i] = (state_q[i] == ST_LOCKED);
      end
   end

   assign idle_out       = idle_q;
   assign all_lanes_idle = all_idle_q;

endmodule
